wb_arbiter: RTL and testbench

- Write-side initiator for the 32x32 register file: merges writeback results from the ALU and the load unit into the single regWr/rd_addr/rd_data write port.
- ALU results have priority and pass through a one-cycle output register.
- Load results are buffered in a small FIFO and drained when the ALU is idle, with starvation protection.
- A probe port reports pending, not-yet-written values so the decode stage can bypass them.

---
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bundle between the ALU/load producers, the register-file write port
// and the decode-stage bypass probe.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) ();
  logic                       alu_valid;
  logic                       alu_ready;
  logic [ADDR_W-1:0]          alu_rd_addr;
  logic [DATA_W-1:0]          alu_rd_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [ADDR_W-1:0]          mem_rd_addr;
  logic [DATA_W-1:0]          mem_rd_data;
  logic                       regWr;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic [$clog2(DEPTH):0]     mem_count;
  logic [ADDR_W-1:0]          probe_addr;
  logic                       probe_hit;
  logic [DATA_W-1:0]          probe_data;

  // The arbiter is the write-side initiator toward the register file.
  modport master (
    input  alu_valid, alu_rd_addr, alu_rd_data,
    input  mem_valid, mem_rd_addr, mem_rd_data,
    input  probe_addr,
    output alu_ready, mem_ready, regWr, rd_addr, rd_data,
    output mem_count, probe_hit, probe_data
  );

  modport slave (
    output alu_valid, alu_rd_addr, alu_rd_data,
    output mem_valid, mem_rd_addr, mem_rd_data,
    output probe_addr,
    input  alu_ready, mem_ready, regWr, rd_addr, rd_data,
    input  mem_count, probe_hit, probe_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write arbiter: ALU results win, load results queue in a FIFO
// and drain when the ALU is idle or has starved the queue for too long.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0]  SC_ONE     = {{(SC_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
  logic [DATA_W-1:0] fifo_data_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [SC_W-1:0]   starve_cnt_r;
  logic              regwr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] rd_data_r;

  logic              empty_s;
  logic              full_s;
  logic              force_s;
  logic              alu_ready_s;
  logic              mem_ready_s;
  logic              alu_win_s;
  logic              pop_s;
  logic              push_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [SC_W-1:0]   starve_nxt_s;
  logic [PTR_W-1:0]  probe_idx_s;
  logic              slot_match_s;
  logic              fifo_hit_s;
  logic [DATA_W-1:0] fifo_hit_data_s;
  logic              probe_hit_s;
  logic [DATA_W-1:0] probe_data_s;

  // Arbitration: the FIFO is forced only after STARVE_LIMIT straight ALU wins.
  always_comb begin
    empty_s     = (count_r == {CNT_W{1'b0}});
    full_s      = (count_r == FULL_CNT);
    force_s     = (starve_cnt_r == STARVE_MAX) && !empty_s;
    alu_ready_s = !force_s && !reset;
    mem_ready_s = !full_s && !reset;
    alu_win_s   = bus.alu_valid && alu_ready_s;
    pop_s       = !alu_win_s && !empty_s && !reset;
    // x0 loads complete the handshake but never occupy a slot.
    push_s      = bus.mem_valid && mem_ready_s && (bus.mem_rd_addr != {ADDR_W{1'b0}});
  end

  // Next-state values for occupancy and the starvation counter.
  always_comb begin
    count_nxt_s  = count_r;
    starve_nxt_s = starve_cnt_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s || empty_s) begin
      starve_nxt_s = {SC_W{1'b0}};
    end else if (alu_win_s) begin
      starve_nxt_s = (starve_cnt_r == STARVE_MAX) ? STARVE_MAX : (starve_cnt_r + SC_ONE);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Bypass probe: later (younger) FIFO slots override older ones, then the output register.
  always_comb begin
    fifo_hit_s      = 1'b0;
    fifo_hit_data_s = {DATA_W{1'b0}};
    probe_idx_s     = rd_ptr_r;
    slot_match_s    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      probe_idx_s     = rd_ptr_r + PTR_W'(i);
      slot_match_s    = (CNT_W'(i) < count_r) && (fifo_addr_r[probe_idx_s] == bus.probe_addr);
      fifo_hit_s      = fifo_hit_s | slot_match_s;
      fifo_hit_data_s = slot_match_s ? fifo_data_r[probe_idx_s] : fifo_hit_data_s;
    end
    if (bus.probe_addr == {ADDR_W{1'b0}}) begin
      probe_hit_s  = 1'b0;
      probe_data_s = {DATA_W{1'b0}};
    end else if (fifo_hit_s) begin
      probe_hit_s  = 1'b1;
      probe_data_s = fifo_hit_data_s;
    end else if (regwr_r && (rd_addr_r == bus.probe_addr)) begin
      probe_hit_s  = 1'b1;
      probe_data_s = rd_data_r;
    end else begin
      probe_hit_s  = 1'b0;
      probe_data_s = {DATA_W{1'b0}};
    end
  end

  // FIFO storage; slot contents are qualified by count_r so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.mem_rd_addr;
      fifo_data_r[wr_ptr_r] <= bus.mem_rd_data;
    end
  end

  // FIFO pointers, occupancy and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      starve_cnt_r <= {SC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r      <= count_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Register-file write port; address/data hold when nothing wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwr_r   <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
    end else if (alu_win_s) begin
      regwr_r   <= (bus.alu_rd_addr != {ADDR_W{1'b0}});
      rd_addr_r <= bus.alu_rd_addr;
      rd_data_r <= bus.alu_rd_data;
    end else if (pop_s) begin
      regwr_r   <= 1'b1;
      rd_addr_r <= fifo_addr_r[rd_ptr_r];
      rd_data_r <= fifo_data_r[rd_ptr_r];
    end else begin
      regwr_r   <= 1'b0;
    end
  end

  assign bus.alu_ready  = alu_ready_s;
  assign bus.mem_ready  = mem_ready_s;
  assign bus.regWr      = regwr_r;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.mem_count  = count_r;
  assign bus.probe_hit  = probe_hit_s;
  assign bus.probe_data = probe_data_s;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Reference model state
  ent_t              q[$];
  int                m_starve;
  logic              m_regwr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              e_alu_rdy;
  logic              e_mem_rdy;

  wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then check combinational outputs against the model.
  task automatic set_in(input logic rst, input logic av, input logic [ADDR_W-1:0] aa,
                        input logic [DATA_W-1:0] ad, input logic mv,
                        input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                        input logic [ADDR_W-1:0] pa);
    logic              e_force;
    logic              e_hit;
    logic [DATA_W-1:0] e_pd;
    reset           = rst;
    bus.alu_valid   = av;
    bus.alu_rd_addr = aa;
    bus.alu_rd_data = ad;
    bus.mem_valid   = mv;
    bus.mem_rd_addr = ma;
    bus.mem_rd_data = md;
    bus.probe_addr  = pa;
    #1;
    e_force   = (m_starve == LIMIT) && (q.size() != 0);
    e_alu_rdy = !rst && !e_force;
    e_mem_rdy = !rst && (q.size() < DEPTH);
    e_hit = 1'b0;
    e_pd  = '0;
    if (pa != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!e_hit && q[i].a == pa) begin
          e_hit = 1'b1;
          e_pd  = q[i].d;
        end
      end
      if (!e_hit && m_regwr && m_addr == pa) begin
        e_hit = 1'b1;
        e_pd  = m_data;
      end
    end
    chk("alu_ready", bus.alu_ready, e_alu_rdy);
    chk("mem_ready", bus.mem_ready, e_mem_rdy);
    chk("mem_count", bus.mem_count, q.size());
    chk("probe_hit", bus.probe_hit, e_hit);
    chk("probe_data", bus.probe_data, e_pd);
  endtask

  // Advance the model by one cycle, clock the DUT and check the write port.
  task automatic tick();
    ent_t e;
    logic nonempty;
    logic mem_acc;
    nonempty = (q.size() != 0);
    mem_acc  = bus.mem_valid && e_mem_rdy;
    if (reset) begin
      q.delete();
      m_starve = 0;
      m_regwr  = 1'b0;
      m_addr   = '0;
      m_data   = '0;
    end else begin
      if (bus.alu_valid && e_alu_rdy) begin
        m_regwr  = (bus.alu_rd_addr != 0);
        m_addr   = bus.alu_rd_addr;
        m_data   = bus.alu_rd_data;
        m_starve = nonempty ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else if (nonempty) begin
        e        = q.pop_front();
        m_regwr  = 1'b1;
        m_addr   = e.a;
        m_data   = e.d;
        m_starve = 0;
      end else begin
        m_regwr  = 1'b0;
        m_starve = 0;
      end
      if (mem_acc && bus.mem_rd_addr != 0) begin
        q.push_back('{a: bus.mem_rd_addr, d: bus.mem_rd_data});
      end
    end
    @(posedge clk);
    #1;
    chk("regWr", bus.regWr, m_regwr);
    if (m_regwr || reset) begin
      chk("rd_addr", bus.rd_addr, m_addr);
      chk("rd_data", bus.rd_data, m_data);
    end
  endtask

  task automatic idle(input logic [ADDR_W-1:0] pa);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, pa);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    checks   = 0;
    failures = 0;
    m_starve = 0;
    m_regwr  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    reset    = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd_addr = '0; bus.alu_rd_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd_addr = '0; bus.mem_rd_data = '0;
    bus.probe_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a load offered
    repeat (2) begin
      set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEAD, 5'd0);
      chk("rst_mem_ready", bus.mem_ready, 1'b0);
      chk("rst_alu_ready", bus.alu_ready, 1'b0);
      tick();
    end
    chk("rst_regWr", bus.regWr, 1'b0);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    chk("post_rst_mem_ready", bus.mem_ready, 1'b1);
    tick();

    // ALU path, one-cycle latency, x0 suppression
    set_in(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    chk("alu_rd_addr", bus.rd_addr, 5'd5);
    chk("alu_rd_data", bus.rd_data, 32'h1234);
    idle(5'd0);
    chk("alu_idle_regWr", bus.regWr, 1'b0);
    set_in(1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    chk("x0_regWr", bus.regWr, 1'b0);

    // Four loads with the ALU idle, drained in order
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'hA0 + 32'(k), 5'd0);
      tick();
    end
    repeat (3) idle(5'd0);

    // Fill the FIFO while the ALU is busy; the fifth load waits for a pop
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b0, 1'b1, 5'd20, 32'(k), 1'b1, 5'(10 + k), 32'hB0 + 32'(k), 5'd0);
      tick();
    end
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      set_in(1'b0, 1'b1, 5'd21, 32'(n), 1'b1, 5'd15, 32'hB5, 5'd0);
      if (n == 0) begin
        chk("full_count", bus.mem_count, 3'd4);
        chk("full_mem_ready", bus.mem_ready, 1'b0);
      end
      acc = e_mem_rdy;
      tick();
    end
    chk("load5_accepted", acc, 1'b1);
    repeat (6) idle(5'd0);

    // Starvation: three ALU wins, then rd=7 is forced out
    set_in(1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd7, 32'h77, 5'd0);
    tick();
    for (int j = 0; j < 3; j++) begin
      set_in(1'b0, 1'b1, 5'(13 + j), 32'(j), 1'b0, 5'd0, 32'd0, 5'd0);
      chk("starve_alu_ready", bus.alu_ready, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b1, 5'd16, 32'h16, 1'b0, 5'd0, 32'd0, 5'd0);
    chk("forced_alu_ready", bus.alu_ready, 1'b0);
    tick();
    chk("forced_rd_addr", bus.rd_addr, 5'd7);
    set_in(1'b0, 1'b1, 5'd16, 32'h16, 1'b0, 5'd0, 32'd0, 5'd0);
    chk("resume_alu_ready", bus.alu_ready, 1'b1);
    tick();
    chk("resume_rd_addr", bus.rd_addr, 5'd16);

    // Probe: youngest match wins, same-cycle push invisible
    set_in(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h11, 5'd0);
    tick();
    set_in(1'b0, 1'b1, 5'd3, 32'h4, 1'b1, 5'd9, 32'h22, 5'd9);
    chk("probe_before_push", bus.probe_data, 32'h11);
    tick();
    set_in(1'b0, 1'b1, 5'd4, 32'h5, 1'b0, 5'd0, 32'd0, 5'd9);
    chk("probe_young_hit", bus.probe_hit, 1'b1);
    chk("probe_young_data", bus.probe_data, 32'h22);
    tick();
    set_in(1'b0, 1'b1, 5'd4, 32'h6, 1'b0, 5'd0, 32'd0, 5'd0);
    chk("probe_x0_hit", bus.probe_hit, 1'b0);
    tick();
    repeat (3) idle(5'd9);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
    chk("probe_drained_hit", bus.probe_hit, 1'b0);
    tick();

    // Push and pop every cycle across pointer wrap
    set_in(1'b0, 1'b1, 5'd6, 32'h6, 1'b1, 5'd21, 32'hC00, 5'd0);
    tick();
    for (int j = 0; j < 10; j++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'((j % 7) + 1), 32'hC01 + 32'(j), 5'd0);
      chk("wrap_count", bus.mem_count, 3'd1);
      tick();
    end
    repeat (2) idle(5'd0);

    // Reset with three entries queued discards them
    for (int j = 0; j < 3; j++) begin
      set_in(1'b0, 1'b1, 5'd8, 32'(j), 1'b1, 5'(j + 1), 32'hD0 + 32'(j), 5'd0);
      tick();
    end
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    tick();
    repeat (3) begin
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
      chk("post_rst_count", bus.mem_count, 3'd0);
      tick();
      chk("post_rst_regWr", bus.regWr, 1'b0);
    end

    // Random traffic against the model
    repeat (400) begin
      set_in(($urandom_range(0, 63) == 0),
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             $urandom(),
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             $urandom(),
             5'($urandom_range(0, 7)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
